// File: rtl/ext_irq_pkg.sv
// rtl/ext_irq_pkg.sv - shared types and constants for the external interrupt controller
package ext_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_e;

   localparam logic [2:0] REG_ENABLE  = 3'd0;
   localparam logic [2:0] REG_EDGE    = 3'd1;
   localparam logic [2:0] REG_PENDING = 3'd2;
   localparam logic [2:0] REG_CLAIM   = 3'd3;
   localparam logic [2:0] REG_STATUS  = 3'd4;

   // Smallest ID width that can encode IDs 0..num_src.
   function automatic int id_width(input int num_src);
      int w;
      w = 1;
      while ((1 << w) <= num_src) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-source synchroniser with registered level and rising-edge pulse
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic src_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_q;
   logic                   rise_q;

   // level_q doubles as the edge history, so level and rise line up on the same cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
         level_q <= sync_q[SYNC_STAGES-1];
         rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - external interrupt controller with fixed priority and claim/complete
module ext_irq_ctrl
   import ext_irq_pkg::*;
#(
   parameter int NUM_SRC     = 16,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = id_width(NUM_SRC)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               irq_ack_i,
   input  logic               reg_we_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic               meip_o,
   output logic [ID_W-1:0]    irq_id_o
);

   logic [NUM_SRC-1:0] level, rise;
   logic [NUM_SRC-1:0] enable_q, edge_q, pend_q, pend_d;
   logic [NUM_SRC-1:0] active, sel_oh, claim_clr, w1c, edge_on, wdata_src;
   logic [ID_W-1:0]    sel_id, id_q, id_d, svc_id_q, svc_id_d;
   logic               meip_q, meip_d, claim_wr;
   irq_state_e         state_q, state_d;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .src_i   (src_i[g]),
         .level_o (level[g]),
         .rise_o  (rise[g])
      );
   end

   assign wdata_src = reg_wdata_i[NUM_SRC-1:0];
   assign claim_wr  = reg_we_i && (reg_addr_i == REG_CLAIM);
   assign w1c       = (reg_we_i && reg_addr_i == REG_PENDING) ? wdata_src : '0;
   assign edge_on   = (reg_we_i && reg_addr_i == REG_EDGE) ? (wdata_src & ~edge_q) : '0;
   assign active    = pend_q & enable_q;

   // Descending scan so the lowest active index is the one left standing.
   always_comb begin
      sel_id = '0;
      sel_oh = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            sel_id    = ID_W'(i + 1);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
         end
      end
   end

   // A new rising edge outranks a clear landing on the same cycle.
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (edge_q[i])
            pend_d[i] = (pend_q[i] & ~(w1c[i] | claim_clr[i])) | rise[i];
         else
            pend_d[i] = level[i] & ~edge_on[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      meip_d    = meip_q;
      id_d      = id_q;
      svc_id_d  = svc_id_q;
      claim_clr = '0;
      case (state_q)
         ST_IDLE: begin
            if (|active) begin
               state_d = ST_REQ;
               meip_d  = 1'b1;
               id_d    = sel_id;
            end
         end
         ST_REQ: begin
            if (active == '0) begin
               state_d = ST_IDLE;
               meip_d  = 1'b0;
               id_d    = '0;
            end else if (irq_ack_i) begin
               state_d   = ST_SERVICE;
               meip_d    = 1'b0;
               id_d      = sel_id;
               svc_id_d  = sel_id;
               claim_clr = sel_oh;
            end else begin
               id_d = sel_id;
            end
         end
         ST_SERVICE: begin
            meip_d = 1'b0;
            id_d   = svc_id_q;
            if (claim_wr && reg_wdata_i == 32'(svc_id_q)) begin
               state_d  = ST_IDLE;
               svc_id_d = '0;
               id_d     = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            meip_d   = 1'b0;
            id_d     = '0;
            svc_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         meip_q   <= 1'b0;
         id_q     <= '0;
         svc_id_q <= '0;
         enable_q <= '0;
         edge_q   <= '0;
         pend_q   <= '0;
      end else begin
         state_q  <= state_d;
         meip_q   <= meip_d;
         id_q     <= id_d;
         svc_id_q <= svc_id_d;
         pend_q   <= pend_d;
         if (reg_we_i && reg_addr_i == REG_ENABLE) enable_q <= wdata_src;
         if (reg_we_i && reg_addr_i == REG_EDGE)   edge_q   <= wdata_src;
      end
   end

   always_comb begin
      case (reg_addr_i)
         REG_ENABLE:  reg_rdata_o = 32'(enable_q);
         REG_EDGE:    reg_rdata_o = 32'(edge_q);
         REG_PENDING: reg_rdata_o = 32'(pend_q);
         REG_CLAIM:   reg_rdata_o = 32'(svc_id_q);
         REG_STATUS:  reg_rdata_o = {30'b0, state_q};
         default:     reg_rdata_o = '0;
      endcase
   end

   assign meip_o   = meip_q;
   assign irq_id_o = id_q;

endmodule

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Parametrised external interrupt controller. Drives the core's machine external interrupt line (meip) from up to NUM_SRC peripheral sources.
- Replaces the ad-hoc "clear meip on irq_ack" behaviour with synchronised inputs, per-source enable, edge/level mode, fixed-priority arbitration and a claim/complete handshake.
- Sits between the peripherals and barebones_wb_top: meip_o feeds meip_i, and irq_ack_o from the core feeds irq_ack_i.
- Software accesses it through a small word-addressed register port decoded on the data bus.

Parameters:
- NUM_SRC, 16, number of interrupt sources (1..31); source i has ID i+1, and ID 0 means none.
- SYNC_STAGES, 2, synchroniser flops per source input (>=2).
- ID_W, 5, width of the ID fields; must satisfy 2^ID_W > NUM_SRC.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- src_i  in  NUM_SRC  raw asynchronous interrupt requests.
- irq_ack_i  in  1  core interrupt-acknowledge pulse.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  3  register word index.
- reg_wdata_i  in  32  register write data.
- reg_rdata_o  out  32  register read data (combinational on reg_addr_i).
- meip_o  out  1  machine external interrupt request to the core.
- irq_id_o  out  ID_W  ID currently requested or in service; 0 if none.

Behaviour:
- Reset (async, active-high) clears to 0: synchronisers, edge history, ENABLE, EDGE, PENDING, in-service ID, FSM (goes to IDLE), meip_o and irq_id_o. Reset mid-service abandons the claim; no completion is required afterwards.
- Register map, by word index:
  - 0 ENABLE: rw.
  - 1 EDGE: rw; 1 = rising-edge mode, 0 = level mode.
  - 2 PENDING: read; write-1-to-clear (edge-mode bits only).
  - 3 CLAIM: read returns the in-service ID; a write with value equal to the in-service ID completes service.
  - 4 STATUS: read {30'b0, state}.
  - Bits at or above NUM_SRC read 0 and ignore writes. Unused addresses read 0.
- Pending, edge mode: the bit sets on a synchronised 0->1 transition. It clears on claim of that source or on a W1C write. A set and a clear in the same cycle leave the bit set.
- Pending, level mode: the bit is the synchronised level, registered; W1C has no effect.
- Mode change: switching EDGE 0->1 clears that bit's pending state in the same write.
- Arbitration: active = PENDING & ENABLE. sel = lowest set index of active; lowest index wins, with no rotation.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if active != 0, go to REQ next edge; meip_o=1 and irq_id_o=sel+1. irq_ack_i is ignored in IDLE.
  - REQ: irq_id_o tracks the current sel each cycle.
    - On irq_ack_i: latch in-service ID = sel+1, clear that edge-mode pending bit, drop meip_o and go to SERVICE, all on the same edge.
    - If active becomes 0 before ack (disable or W1C): drop meip_o, set irq_id_o=0 and return to IDLE.
  - SERVICE: meip_o=0 and irq_id_o=in-service ID.
    - A CLAIM write with a matching ID: clear the in-service ID and go to IDLE. A new request can then assert meip_o no sooner than the following cycle.
    - A mismatched CLAIM write is ignored.
    - ENABLE/EDGE writes do not abort service.
    - A level source that is still high re-requests after completion.
- Latency: a src_i rising edge first sampled at edge 0 sets pending at edge SYNC_STAGES+1 and asserts meip_o at edge SYNC_STAGES+2, assuming IDLE and the source enabled.
- Same-cycle conflicts: W1C of the selected bit in the same cycle as irq_ack_i lets the ack win.

Decomposition:
- Shared package ext_irq_pkg holds:
  - the FSM state encoding: IDLE=0, REQ=1, SERVICE=2;
  - register index constants: ENABLE=0, EDGE=1, PENDING=2, CLAIM=3, STATUS=4;
  - the ID_W derivation helper.
- One natural sub-module, irq_sync_edge: a per-source synchroniser with edge detect, instantiated via generate over NUM_SRC.
- Arbitration (priority encoder) and the FSM stay in the top level.

Test Plan:
1. Reset, then write ENABLE=0x0001 and EDGE=0x0001, then pulse src_i[0] for 1 cycle -> meip_o=1 and irq_id_o=1 at edge SYNC_STAGES+2. After irq_ack_i: meip_o=0, PENDING=0, CLAIM reads 1, STATUS reads 2.
2. Edge sources 3 and 7 enabled, both pulsed in the same cycle -> irq_id_o=4. After ack then CLAIM write 4: meip_o re-asserts with irq_id_o=8, and PENDING reads 0x80 until the second ack.
3. Level source 2 held high: ack, then complete with CLAIM write 3 -> meip_o re-asserts. Drop src_i[2] -> after SYNC_STAGES+1 cycles PENDING bit 2=0 and no further request.
4. In REQ for ID 1: write ENABLE=0 -> meip_o=0, irq_id_o=0, STATUS=0. In SERVICE: a CLAIM write of 5 when ID 1 is in service is ignored (STATUS stays 2).
5. Edge src_i[0] pulses again in the same cycle its pending bit is claimed -> PENDING bit 0 remains 1, and meip_o re-asserts after completion.
6. Assert reset_i asynchronously mid-SERVICE -> meip_o, irq_id_o and all registers read 0 immediately. After release, no completion is required before a new request is served.
